fetch_decode_unit: RTL

//   Program-counter / instruction-register stage for the "Frankie" CPU, directly upstream of the control unit.

---
 rtl/fetch_decode_unit.sv | 127 ++++++++++++
 1 files changed

// File: rtl/fetch_decode_unit.sv
// fetch_decode_unit
//   Program-counter / instruction-register stage of the Frankie CPU. Holds
//   PC, IR, RA, the compare flag and a few status registers, and applies the
//   control unit's write strobes on each rising edge of CLK.
// Ports
//   CLK, Reset                 clock, async active-high reset
//   MemData, Mary, Shelley     data sources (memory word, accumulator, @ reg)
//   ALUResult                  ALU output, bit 0 = compare result
//   InstWrite, PCWrite, PCSrc  IR latch, PC update and next-PC select
//   RAWrite, RASrc, CompWrite  RA update/source, compare-flag latch
//   PC, RA, Comp               registered state
//   OPCODE, flagbit, Imm       combinational split of IR
//   IRValid, Misalign          status (instruction latched, odd jump target)
//   InstCount                  wrapping count of InstWrite pulses
module fetch_decode_unit #(
  parameter int              WIDTH    = 16,
  parameter int              OP_W     = 5,
  parameter int              IMM_W    = 10,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter logic [WIDTH-1:0] PC_STEP  = WIDTH'(2)
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [WIDTH-1:0] MemData,
  input  logic [WIDTH-1:0] Mary,
  input  logic [WIDTH-1:0] Shelley,
  input  logic [WIDTH-1:0] ALUResult,
  input  logic             InstWrite,
  input  logic             PCWrite,
  input  logic [2:0]       PCSrc,
  input  logic             RAWrite,
  input  logic             RASrc,
  input  logic             CompWrite,
  output logic [WIDTH-1:0] PC,
  output logic [OP_W-1:0]  OPCODE,
  output logic             flagbit,
  output logic [WIDTH-1:0] Imm,
  output logic [WIDTH-1:0] RA,
  output logic             Comp,
  output logic             IRValid,
  output logic             Misalign,
  output logic [WIDTH-1:0] InstCount
);

  logic [WIDTH-1:0] pc_q, pc_d, ir_q, ir_d, ra_q, ra_d, cnt_q, cnt_d;
  logic             comp_q, comp_d, valid_q, valid_d, mis_q, mis_d;

  // Pseudo-direct target: top PC bits kept, immediate is a halfword index.
  logic [WIDTH-1:0] jmp;
  assign jmp = {pc_q[WIDTH-1:IMM_W+1], ir_q[IMM_W-1:0], 1'b0};

  // Register-sourced target selected this cycle (if any).
  logic             reg_tgt;
  logic [WIDTH-1:0] reg_val;

  always_comb begin
    pc_d    = pc_q;
    ir_d    = ir_q;
    ra_d    = ra_q;
    cnt_d   = cnt_q;
    comp_d  = comp_q;
    valid_d = valid_q;
    mis_d   = mis_q;
    reg_tgt = 1'b0;
    reg_val = '0;

    if (PCWrite) begin
      unique case (PCSrc)
        3'b000: pc_d = pc_q + PC_STEP;
        3'b010: pc_d = jmp;
        3'b110: pc_d = comp_q ? jmp : pc_q;
        3'b001,
        3'b101: begin reg_tgt = 1'b1; reg_val = Shelley; end
        3'b011: begin reg_tgt = 1'b1; reg_val = ra_q;    end
        3'b100: begin reg_tgt = 1'b1; reg_val = Mary;    end
        3'b111: begin reg_tgt = comp_q; reg_val = Shelley; end
        default: pc_d = pc_q;
      endcase
      // Instructions are halfword aligned: drop bit 0, but remember it happened.
      if (reg_tgt) begin
        pc_d = {reg_val[WIDTH-1:1], 1'b0};
        if (reg_val[0]) mis_d = 1'b1;
      end
    end

    if (InstWrite) begin
      ir_d    = MemData;
      valid_d = 1'b1;
      cnt_d   = cnt_q + WIDTH'(1);
    end

    // RASrc=1 links the pre-edge PC, which Fetch has already advanced.
    if (RAWrite)   ra_d   = RASrc ? pc_q : MemData;
    if (CompWrite) comp_d = ALUResult[0];
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      ra_q    <= '0;
      cnt_q   <= '0;
      comp_q  <= 1'b0;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      ra_q    <= ra_d;
      cnt_q   <= cnt_d;
      comp_q  <= comp_d;
      valid_q <= valid_d;
      mis_q   <= mis_d;
    end
  end

  assign PC        = pc_q;
  assign OPCODE    = ir_q[WIDTH-1 -: OP_W];
  assign flagbit   = ir_q[IMM_W];
  assign Imm       = {{(WIDTH-IMM_W){1'b0}}, ir_q[IMM_W-1:0]};
  assign RA        = ra_q;
  assign Comp      = comp_q;
  assign IRValid   = valid_q;
  assign Misalign  = mis_q;
  assign InstCount = cnt_q;

endmodule
